// File: rtl/span_scheduler_if.sv
// rtl/span_scheduler_if.sv - requester and span-engine signal bundle for span_scheduler
// slave modport is the scheduler side; master is the requesters/engine side.
interface span_scheduler_if #(
  parameter int CW = 16
);
  logic            req0;
  logic [5*CW-1:0] span0;
  logic            ack0;
  logic            req1;
  logic [5*CW-1:0] span1;
  logic            ack1;
  logic            eng_start;
  logic [CW-1:0]   eng_x0;
  logic [CW-1:0]   eng_x1;
  logic [CW-1:0]   eng_y0;
  logic [CW-1:0]   eng_y1;
  logic [CW-1:0]   eng_z1;
  logic [CW-1:0]   eng_z2;
  logic            eng_done;
  logic            busy;
  logic [15:0]     span_count;
  logic [7:0]      reject_count;

  modport slave (
    input  req0, span0, req1, span1, eng_done,
    output ack0, ack1, eng_start, eng_x0, eng_x1, eng_y0, eng_y1,
           eng_z1, eng_z2, busy, span_count, reject_count
  );

  modport master (
    output req0, span0, req1, span1, eng_done,
    input  ack0, ack1, eng_start, eng_x0, eng_x1, eng_y0, eng_y1,
           eng_z1, eng_z2, busy, span_count, reject_count
  );
endinterface

// File: rtl/span_scheduler.sv
// rtl/span_scheduler.sv - round-robin span request arbiter and span engine launcher
// SPAN_SWAP_EN: reversed spans (x0 > x1) are normalised and launched instead of dropped.
module span_scheduler #(
  parameter int CW = 16
) (
  input logic clk,
  input logic reset,
  span_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]    r_state;
  logic          r_ptr;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_start;
  logic [CW-1:0] r_x0;
  logic [CW-1:0] r_x1;
  logic [CW-1:0] r_y;
  logic [CW-1:0] r_z1;
  logic [CW-1:0] r_z2;
  logic [15:0]   r_span_cnt;
  logic [7:0]    r_rej_cnt;

  logic            w_any_req;
  logic            w_sel1;
  logic [5*CW-1:0] w_span;
  logic [CW-1:0]   w_x0;
  logic [CW-1:0]   w_x1;
  logic [CW-1:0]   w_y;
  logic [CW-1:0]   w_z1;
  logic [CW-1:0]   w_z2;
  logic            w_rev;
  logic            w_accept;
  logic            w_swap;

  // A lone requester wins outright; the pointer only breaks ties.
  assign w_any_req = bus.req0 | bus.req1;
  assign w_sel1    = bus.req1 & (~bus.req0 | r_ptr);
  assign w_span    = w_sel1 ? bus.span1 : bus.span0;
  assign w_x0      = w_span[5*CW-1 -: CW];
  assign w_x1      = w_span[4*CW-1 -: CW];
  assign w_y       = w_span[3*CW-1 -: CW];
  assign w_z1      = w_span[2*CW-1 -: CW];
  assign w_z2      = w_span[CW-1:0];
  assign w_rev     = w_x0 > w_x1;

`ifdef SPAN_SWAP_EN
  assign w_accept = 1'b1;
  assign w_swap   = w_rev;
`else
  assign w_accept = ~w_rev;
  assign w_swap   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_start    <= 1'b0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y        <= '0;
      r_z1       <= '0;
      r_z2       <= '0;
      r_span_cnt <= '0;
      r_rej_cnt  <= '0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_ack0 <= ~w_sel1;
            r_ack1 <= w_sel1;
            r_ptr  <= ~w_sel1;
            if (w_accept) begin
              r_x0    <= w_swap ? w_x1 : w_x0;
              r_x1    <= w_swap ? w_x0 : w_x1;
              r_y     <= w_y;
              r_z1    <= w_swap ? w_z2 : w_z1;
              r_z2    <= w_swap ? w_z1 : w_z2;
              r_state <= S_LAUNCH;
            end else if (r_rej_cnt != 8'hFF) begin
              r_rej_cnt <= r_rej_cnt + 8'd1;
            end
          end
        end
        S_LAUNCH: begin
          r_start    <= 1'b1;
          r_span_cnt <= r_span_cnt + 16'd1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.eng_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0         = r_ack0;
  assign bus.ack1         = r_ack1;
  assign bus.eng_start    = r_start;
  assign bus.eng_x0       = r_x0;
  assign bus.eng_x1       = r_x1;
  assign bus.eng_y0       = r_y;
  assign bus.eng_y1       = r_y;
  assign bus.eng_z1       = r_z1;
  assign bus.eng_z2       = r_z2;
  assign bus.busy         = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign bus.span_count   = r_span_cnt;
  assign bus.reject_count = r_rej_cnt;
endmodule

// File: tb/tb_span_scheduler.sv
// tb/tb_span_scheduler.sv - randomized bench for span_scheduler against a transaction-level model
// Model tracks requester queues, grant preference, in-flight span and counters per cycle.
module tb_span_scheduler;
  logic clk;
  logic reset;

  span_scheduler_if #(.CW(16)) sif ();

  span_scheduler #(.CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [79:0] q0[$];
  logic [79:0] q1[$];
  bit          grants[$];

  bit          raised0, raised1;
  bit          d_req0, d_req1, d_done, d_rst;
  bit          want_rst, force_done, gaps, spur;
  int          done_wait;

  bit          m_busy, m_pend, m_started, m_pref;
  logic [15:0] m_span_cnt;
  logic [7:0]  m_rej;
  logic [95:0] m_eng;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [15:0] x0, x1, y, z1, z2);
    return {x0, x1, y, z1, z2};
  endfunction

  task automatic model_reset();
    m_busy     = 1'b0;
    m_pend     = 1'b0;
    m_started  = 1'b0;
    m_pref     = 1'b0;
    m_span_cnt = '0;
    m_rej      = '0;
    m_eng      = '0;
  endtask

  task automatic step();
    bit          e_ack0, e_ack1, e_start, idle_before, g, rev;
    logic [79:0] sp;
    logic [15:0] x0, x1, y, z1, z2;
    @(negedge clk);
    e_ack0  = 1'b0;
    e_ack1  = 1'b0;
    e_start = 1'b0;
    if (d_rst) begin
      model_reset();
    end else begin
      idle_before = !m_busy;
      e_start     = m_pend;
      if (d_done && m_started) begin
        m_busy    = 1'b0;
        m_started = 1'b0;
      end
      if (m_pend) begin
        m_pend     = 1'b0;
        m_started  = 1'b1;
        m_span_cnt = m_span_cnt + 16'd1;
        done_wait  = $urandom_range(0, 4);
      end
      if (idle_before && (d_req0 || d_req1)) begin
        g = (d_req0 && d_req1) ? m_pref : d_req1;
        if (g) begin
          sp = q1.pop_front();
          raised1 = 1'b0;
          e_ack1 = 1'b1;
        end else begin
          sp = q0.pop_front();
          raised0 = 1'b0;
          e_ack0 = 1'b1;
        end
        grants.push_back(g);
        m_pref = !g;
        {x0, x1, y, z1, z2} = sp;
        rev = x0 > x1;
`ifdef SPAN_SWAP_EN
        if (rev) begin
          {x0, x1} = {x1, x0};
          {z1, z2} = {z2, z1};
        end
        rev = 1'b0;
`endif
        if (rev) begin
          if (m_rej != 8'hFF) m_rej = m_rej + 8'd1;
        end else begin
          m_eng  = {x0, x1, y, y, z1, z2};
          m_busy = 1'b1;
          m_pend = 1'b1;
        end
      end
    end

    check("ack0", 96'(sif.ack0), 96'(e_ack0));
    check("ack1", 96'(sif.ack1), 96'(e_ack1));
    check("eng_start", 96'(sif.eng_start), 96'(e_start));
    check("busy", 96'(sif.busy), 96'(m_busy));
    check("eng_data", {sif.eng_x0, sif.eng_x1, sif.eng_y0, sif.eng_y1, sif.eng_z1, sif.eng_z2}, m_eng);
    check("span_count", 96'(sif.span_count), 96'(m_span_cnt));
    check("reject_count", 96'(sif.reject_count), 96'(m_rej));

    reset    = want_rst;
    d_rst    = want_rst;
    want_rst = 1'b0;
    if (!raised0 && q0.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) raised0 = 1'b1;
    if (!raised1 && q1.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) raised1 = 1'b1;
    d_req0 = raised0;
    d_req1 = raised1;
    sif.req0 = raised0;
    sif.req1 = raised1;
    if (raised0) sif.span0 = q0[0];
    if (raised1) sif.span1 = q1[0];
    if (force_done) begin
      d_done = 1'b1;
      force_done = 1'b0;
    end else if (m_started) begin
      if (done_wait == 0) begin
        d_done = 1'b1;
      end else begin
        done_wait--;
        d_done = 1'b0;
      end
    end else begin
      d_done = spur && ($urandom_range(0, 7) == 0);
    end
    sif.eng_done = d_done;
  endtask

  task automatic run(input int bound);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < bound) begin
      step();
      n++;
    end
    check("drain", 96'(q0.size() + q1.size() + int'(m_busy)), 96'(0));
  endtask

  task automatic do_reset();
    want_rst = 1'b1;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    d_rst = 1'b1;
    sif.req0 = 1'b0;
    sif.req1 = 1'b0;
    sif.span0 = '0;
    sif.span1 = '0;
    sif.eng_done = 1'b0;
    {raised0, raised1, d_req0, d_req1, d_done} = '0;
    {want_rst, force_done, gaps, spur} = '0;
    done_wait = 0;
    model_reset();
    step();

    q0.push_back(mk(16'd10, 16'd20, 16'd5, 16'd100, 16'd200));
    run(50);
    check("single_count", 96'(sif.span_count), 96'(1));

    do_reset();
    grants.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(16'(i), 16'(i + 8), 16'($urandom), 16'($urandom), 16'($urandom)));
      q1.push_back(mk(16'(i + 3), 16'(i + 3), 16'($urandom), 16'($urandom), 16'($urandom)));
    end
    run(100);
    check("cont_grants", 96'(grants.size()), 96'(4));
    for (int i = 0; i < grants.size() && i < 4; i++) check("cont_order", 96'(grants[i]), 96'(i % 2));
    check("cont_count", 96'(sif.span_count), 96'(4));

    do_reset();
    q0.push_back(mk(16'd30, 16'd12, 16'd3, 16'd7, 16'd9));
    run(50);
`ifdef SPAN_SWAP_EN
    check("rev_x0", 96'(sif.eng_x0), 96'(12));
    check("rev_z1", 96'(sif.eng_z1), 96'(9));
`else
    check("rev_reject", 96'(sif.reject_count), 96'(1));
    check("rev_count", 96'(sif.span_count), 96'(0));
`endif

    q0.push_back(mk(16'd1, 16'd40, 16'd2, 16'd3, 16'd4));
    for (int n = 0; n < 20 && !m_started; n++) step();
    want_rst = 1'b1;
    step();
    grants.delete();
    q1.push_back(mk(16'd5, 16'd6, 16'd7, 16'd8, 16'd9));
    force_done = 1'b1;
    step();
    run(50);
    check("rst_grants", 96'(grants.size()), 96'(1));
    if (grants.size() > 0) check("rst_first", 96'(grants[0]), 96'(1));

    gaps = 1'b1;
    spur = 1'b1;
    for (int i = 0; i < 40; i++) begin
      q0.push_back(mk(16'($urandom_range(0, 40)), 16'($urandom_range(0, 40)), 16'($urandom),
                      16'($urandom), 16'($urandom)));
      q1.push_back(mk(16'($urandom_range(0, 40)), 16'($urandom_range(0, 40)), 16'($urandom),
                      16'($urandom), 16'($urandom)));
    end
    run(5000);
    gaps = 1'b0;
    spur = 1'b0;

`ifndef SPAN_SWAP_EN
    do_reset();
    for (int i = 0; i < 300; i++) q0.push_back(mk(16'd50, 16'(i % 50), 16'd1, 16'd2, 16'd3));
    run(1000);
    check("sat_reject", 96'(sif.reject_count), 96'(255));
    check("sat_count", 96'(sif.span_count), 96'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
